// File: rtl/mult_issue_ctrl_pkg.sv
// Shared constants and bundle types for the multiplier issue/result control.
// Imported by mult_result_fifo and mult_issue_ctrl.
package mult_issue_ctrl_pkg;

  localparam int MULT_LATENCY = 8;
  localparam int RESULT_DEPTH = 4;
  localparam int TAG_W        = 6;
  localparam int ROB_W        = 5;
  localparam int OCC_W        = $clog2(RESULT_DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [ROB_W-1:0] rob_idx;
  } mult_meta_t;

  typedef struct packed {
    logic [63:0] value;
    mult_meta_t  meta;
  } mult_result_t;

endpackage

// File: rtl/mult_result_fifo.sv
// Circular result buffer; DEPTH must be a power of two (>= 2).
// Ports: push/push_data in, pop in, nuke clears, full/empty/head out.
module mult_result_fifo
  import mult_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = RESULT_DEPTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         nuke,
  input  logic         push,
  input  mult_result_t push_data,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output mult_result_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  // One extra pointer bit tells full from empty.
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  mult_result_t mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                 (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (nuke) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/result control around the 8-stage multiplier: credit-gated issue,
// shadow tag pipeline, result buffer toward the CDB, sticky proto_err.
module mult_issue_ctrl
  import mult_issue_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             nuke,
  input  logic             issue_valid,
  input  logic [63:0]      issue_opa,
  input  logic [63:0]      issue_opb,
  input  logic [TAG_W-1:0] issue_tag,
  input  logic [ROB_W-1:0] issue_rob_idx,
  output logic             issue_ready,
  output logic             mult_start,
  output logic [63:0]      mult_mcand,
  output logic [63:0]      mult_mplier,
  input  logic [63:0]      mult_product,
  input  logic             mult_done,
  output logic             cdb_req,
  output logic [63:0]      cdb_value,
  output logic [TAG_W-1:0] cdb_tag,
  output logic [ROB_W-1:0] cdb_rob_idx,
  input  logic             cdb_grant,
  output logic             proto_err
);

  localparam int L = MULT_LATENCY;

  logic [OCC_W-1:0]  occ;
  logic              accept;
  logic              pop;
  logic [L-1:0]      sh_valid;
  mult_meta_t        sh_meta [L];
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              mismatch;
  mult_result_t      push_data;
  mult_result_t      head;

  // occ counts ops in flight plus ops buffered, so the buffer
  // can never overflow while the multiplier runs without stalls.
  assign issue_ready = (occ < OCC_W'(RESULT_DEPTH)) && !nuke;
  assign accept      = issue_valid && issue_ready;
  assign mult_start  = accept;
  assign mult_mcand  = issue_opa;
  assign mult_mplier = issue_opb;
  assign pop         = cdb_req && cdb_grant;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      occ <= '0;
    end else if (nuke) begin
      occ <= '0;
    end else if (accept && !pop) begin
      occ <= occ + OCC_W'(1);
    end else if (pop && !accept && occ != '0) begin
      occ <= occ - OCC_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_valid <= '0;
      for (int i = 0; i < L; i++) begin
        sh_meta[i] <= '0;
      end
    end else begin
      sh_valid <= nuke ? '0 : {sh_valid[L-2:0], accept};
      sh_meta[0] <= '{tag: issue_tag, rob_idx: issue_rob_idx};
      for (int i = 1; i < L; i++) begin
        sh_meta[i] <= sh_meta[i-1];
      end
    end
  end

  // A done without a matching shadow entry is still pushed;
  // only a missing done suppresses the push.
  assign fifo_push = mult_done && !nuke;
  assign mismatch  = (mult_done != sh_valid[L-1]) && !nuke;
  assign push_data = '{value: mult_product, meta: sh_meta[L-1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if (mismatch || (fifo_push && fifo_full)) begin
      proto_err <= 1'b1;
    end
  end

  mult_result_fifo #(
    .DEPTH(RESULT_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .nuke      (nuke),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign cdb_req     = !fifo_empty;
  assign cdb_value   = head.value;
  assign cdb_tag     = head.meta.tag;
  assign cdb_rob_idx = head.meta.rob_idx;

endmodule
